// File: rtl/alu_decode_stage.sv
// Decode stage: turns an RV32I instruction into ALU control, operand selects and immediate,
// buffered by a main/skid register pair so in_ready comes straight from a flop.
module alu_decode_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] pc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_ctrl,
  output logic [1:0]       alu_src_a,
  output logic             alu_src_b,
  output logic [WIDTH-1:0] imm_ext,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic             reg_write,
  output logic             illegal,
  output logic [WIDTH-1:0] pc_out
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1101;

  typedef struct packed {
    logic [3:0]       alu_ctrl;
    logic [1:0]       src_a;
    logic             src_b;
    logic [WIDTH-1:0] imm;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic             reg_write;
    logic             illegal;
    logic [WIDTH-1:0] pc;
  } entry_t;

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [3:0]       base_ctrl;
  logic             alt;
  logic             f7_ok;
  logic             is_shift;
  logic [WIDTH-1:0] imm_i;
  logic [WIDTH-1:0] imm_s;
  logic [WIDTH-1:0] imm_b;
  logic [WIDTH-1:0] imm_u;
  logic [WIDTH-1:0] imm_j;
  logic [WIDTH-1:0] imm_sh;
  entry_t           dec;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign alt      = funct7[5];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  // Only ADD/SUB and SRL/SRA have an alternate encoding; every other funct7 is rejected.
  assign f7_ok    = (funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

  assign imm_i  = {{(WIDTH-12){instr[31]}}, instr[31:20]};
  assign imm_s  = {{(WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{(WIDTH-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {{(WIDTH-32){instr[31]}}, instr[31:12], 12'b0};
  assign imm_j  = {{(WIDTH-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_sh = {{(WIDTH-5){1'b0}}, instr[24:20]};

  always_comb begin
    base_ctrl = ALU_ADD;
    case (funct3)
      3'b000:  base_ctrl = ALU_ADD;
      3'b001:  base_ctrl = ALU_SLL;
      3'b010:  base_ctrl = ALU_SLT;
      3'b011:  base_ctrl = ALU_SLTU;
      3'b100:  base_ctrl = ALU_XOR;
      3'b101:  base_ctrl = ALU_SRL;
      3'b110:  base_ctrl = ALU_OR;
      default: base_ctrl = ALU_AND;
    endcase
  end

  always_comb begin
    dec           = '0;
    dec.rs1       = instr[19:15];
    dec.rs2       = instr[24:20];
    dec.rd        = instr[11:7];
    dec.pc        = pc_in;
    dec.alu_ctrl  = ALU_ADD;
    dec.reg_write = 1'b1;
    case (opcode)
      OPC_OP: begin
        if (funct3 == 3'b000 && alt)      dec.alu_ctrl = ALU_SUB;
        else if (funct3 == 3'b101 && alt) dec.alu_ctrl = ALU_SRA;
        else                              dec.alu_ctrl = base_ctrl;
        dec.illegal = !f7_ok;
      end
      OPC_OP_IMM: begin
        dec.src_b = 1'b1;
        if (funct3 == 3'b101 && alt) dec.alu_ctrl = ALU_SRA;
        else                         dec.alu_ctrl = base_ctrl;
        dec.imm     = is_shift ? imm_sh : imm_i;
        dec.illegal = is_shift && !f7_ok;
      end
      OPC_LOAD, OPC_JALR: begin
        dec.src_b = 1'b1;
        dec.imm   = imm_i;
      end
      OPC_STORE: begin
        dec.src_b     = 1'b1;
        dec.imm       = imm_s;
        dec.reg_write = 1'b0;
      end
      OPC_BRANCH: begin
        dec.alu_ctrl  = ALU_SUB;
        dec.imm       = imm_b;
        dec.reg_write = 1'b0;
        dec.illegal   = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LUI: begin
        dec.src_a = 2'd2;
        dec.src_b = 1'b1;
        dec.imm   = imm_u;
      end
      OPC_AUIPC: begin
        dec.src_a = 2'd1;
        dec.src_b = 1'b1;
        dec.imm   = imm_u;
      end
      OPC_JAL: begin
        dec.src_a = 2'd1;
        dec.src_b = 1'b1;
        dec.imm   = imm_j;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.alu_ctrl  = ALU_ADD;
      dec.reg_write = 1'b0;
    end
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
  end

  entry_t main_reg;
  entry_t skid_reg;
  logic   main_valid_reg;
  logic   skid_valid_reg;
  logic   accept;
  logic   drain;

  assign in_ready = ~skid_valid_reg;
  assign accept   = in_valid & ~skid_valid_reg;
  assign drain    = main_valid_reg & out_ready;

  // Skid only fills while main is stalled, so main is never empty with skid full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_reg       <= '0;
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (flush) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (!main_valid_reg || drain) begin
      if (skid_valid_reg) begin
        main_reg       <= skid_reg;
        main_valid_reg <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else if (accept) begin
        main_reg       <= dec;
        main_valid_reg <= 1'b1;
      end else begin
        main_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      skid_reg       <= dec;
      skid_valid_reg <= 1'b1;
    end
  end

  assign out_valid = main_valid_reg;
  assign alu_ctrl  = main_reg.alu_ctrl;
  assign alu_src_a = main_reg.src_a;
  assign alu_src_b = main_reg.src_b;
  assign imm_ext   = main_reg.imm;
  assign rs1       = main_reg.rs1;
  assign rs2       = main_reg.rs2;
  assign rd        = main_reg.rd;
  assign reg_write = main_reg.reg_write;
  assign illegal   = main_reg.illegal;
  assign pc_out    = main_reg.pc;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: directed decode cases, backpressure, flush, reset,
// and a randomized run scored against a queue-based reference model.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_ctrl;
  logic [1:0]  alu_src_a;
  logic        alu_src_b;
  logic [31:0] imm_ext;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        reg_write;
  logic        illegal;
  logic [31:0] pc_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_decode_stage #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc_in(pc_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_ext(imm_ext),
    .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write), .illegal(illegal), .pc_out(pc_out)
  );

  typedef struct {
    logic [3:0]  ctrl;
    logic [1:0]  sa;
    logic        sb;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];

  // funct3 -> operation for register/immediate arithmetic (non-alternate forms)
  localparam logic [3:0] BASE_TBL [8] = '{4'd0, 4'd6, 4'd5, 4'd13, 4'd4, 4'd7, 4'd3, 4'd2};

  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    int   f3 = int'(w[14:12]);
    int   f7 = int'(w[31:25]);
    int   ival = $signed(w) >>> 20;
    int   bval = (w[31] ? -4096 : 0) + (w[7] ? 2048 : 0) + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    int   jval = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + (w[20] ? 2048 : 0) + int'(w[30:21]) * 2;
    e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.pc = pc;
    e.ctrl = 4'd0; e.sa = 2'd0; e.sb = 1'b1; e.rw = 1'b1; e.ill = 1'b0; e.imm = 32'(ival);
    case (w[6:0])
      7'h33: begin
        e.sb = 1'b0; e.imm = 32'd0;
        e.ctrl = BASE_TBL[w[14:12]];
        if (w[30] && f3 == 0) e.ctrl = 4'd1;
        if (w[30] && f3 == 5) e.ctrl = 4'd8;
        e.ill = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
      end
      7'h13: begin
        e.ctrl = BASE_TBL[w[14:12]];
        if (w[30] && f3 == 5) e.ctrl = 4'd8;
        if (f3 == 1 || f3 == 5) e.imm = 32'(w[24:20]);
        e.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32);
      end
      7'h03, 7'h67: ;
      7'h23: begin e.imm = (32'(ival) & 32'hFFFFFFE0) | 32'(w[11:7]); e.rw = 1'b0; end
      7'h63: begin
        e.sb = 1'b0; e.ctrl = 4'd1; e.imm = 32'(bval); e.rw = 1'b0;
        e.ill = (f3 == 2 || f3 == 3);
      end
      7'h37: begin e.sa = 2'd2; e.imm = w & 32'hFFFFF000; end
      7'h17: begin e.sa = 2'd1; e.imm = w & 32'hFFFFF000; end
      7'h6F: begin e.sa = 2'd1; e.imm = 32'(jval); end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin e.ctrl = 4'd0; e.rw = 1'b0; end
    if (e.rd == 5'd0) e.rw = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 11))
      0, 9:    w[6:0] = 7'h33;
      1:       w[6:0] = 7'h13;
      2:       w[6:0] = 7'h03;
      3:       w[6:0] = 7'h67;
      4:       w[6:0] = 7'h23;
      5:       w[6:0] = 7'h63;
      6:       w[6:0] = 7'h37;
      7:       w[6:0] = 7'h17;
      8:       w[6:0] = 7'h6F;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0:       w[31:25] = 7'h00;
      1:       w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  // Drives one clock of stimulus from a negedge and advances the model; returns at the next negedge.
  task automatic cycle(input logic v, input logic [31:0] w, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    logic exp_ready;
    logic exp_out;
    in_valid = v; instr = w; pc_in = pc; out_ready = ordy; flush = fl;
    exp_ready = (q.size() < 2);
    exp_out   = (q.size() > 0);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (exp_out && ordy) void'(q.pop_front());
      if (v && exp_ready) q.push_back(ref_decode(w, pc));
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; pc_in = '0; out_ready = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if ({alu_ctrl, alu_src_a, alu_src_b, reg_write, illegal} !== 9'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", {alu_ctrl, alu_src_a, alu_src_b, reg_write, illegal}); end
    n_checks++; if ({imm_ext, pc_out, rs1, rs2, rd} !== 79'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {imm_ext, pc_out, rs1, rs2, rd}); end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b want 0", out_valid); end
    $display("test_reset done");
  endtask

  task automatic test_decode();
    cycle(1'b1, 32'h002081B3, 32'h100, 1'b1, 1'b0);  // add x3,x1,x2
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_latency: got %b want 1", out_valid); end
    n_checks++; if ({alu_ctrl, alu_src_b, rd, rs1, rs2, reg_write, illegal} !== {4'd0, 1'b0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0})
      begin n_fail++; $display("FAIL add_fields: got ctrl %h srcb %b rd %0d rs1 %0d rs2 %0d rw %b ill %b", alu_ctrl, alu_src_b, rd, rs1, rs2, reg_write, illegal); end
    n_checks++; if (pc_out !== 32'h100) begin n_fail++; $display("FAIL add_pc: got %h want 100", pc_out); end
    cycle(1'b1, 32'h402081B3, 32'h104, 1'b1, 1'b0);  // sub
    n_checks++; if (alu_ctrl !== 4'b0001) begin n_fail++; $display("FAIL sub_ctrl: got %b want 0001", alu_ctrl); end
    cycle(1'b1, 32'h40335293, 32'h108, 1'b1, 1'b0);  // srai x5,x6,3
    n_checks++; if ({alu_ctrl, alu_src_b, imm_ext, rd} !== {4'b1000, 1'b1, 32'h3, 5'd5})
      begin n_fail++; $display("FAIL srai: got ctrl %b srcb %b imm %h rd %0d want 1000 1 00000003 5", alu_ctrl, alu_src_b, imm_ext, rd); end
    cycle(1'b1, 32'hFE000EE3, 32'h10C, 1'b1, 1'b0);  // beq x0,x0,-4
    n_checks++; if ({alu_ctrl, reg_write, alu_src_b, illegal} !== {4'b0001, 1'b0, 1'b0, 1'b0})
      begin n_fail++; $display("FAIL beq_ctrl: got ctrl %b rw %b srcb %b ill %b", alu_ctrl, reg_write, alu_src_b, illegal); end
    n_checks++; if (imm_ext !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL beq_imm: got %h want fffffffc", imm_ext); end
    cycle(1'b1, 32'h123452B7, 32'h110, 1'b1, 1'b0);  // lui x5,0x12345
    n_checks++; if ({alu_src_a, alu_src_b, imm_ext, reg_write} !== {2'd2, 1'b1, 32'h12345000, 1'b1})
      begin n_fail++; $display("FAIL lui: got srca %0d srcb %b imm %h rw %b", alu_src_a, alu_src_b, imm_ext, reg_write); end
    cycle(1'b1, 32'h00208033, 32'h114, 1'b1, 1'b0);  // add x0,x1,x2
    n_checks++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL rd0_rw: got %b want 0", reg_write); end
    cycle(1'b1, 32'hFFFFFFFF, 32'h118, 1'b1, 1'b0);
    n_checks++; if ({illegal, alu_ctrl, reg_write} !== {1'b1, 4'd0, 1'b0})
      begin n_fail++; $display("FAIL ill_ones: got ill %b ctrl %b rw %b want 1 0000 0", illegal, alu_ctrl, reg_write); end
    cycle(1'b1, 32'h022081B3, 32'h11C, 1'b1, 1'b0);  // OP with funct7 0000001
    n_checks++; if ({illegal, alu_ctrl, reg_write} !== {1'b1, 4'd0, 1'b0})
      begin n_fail++; $display("FAIL ill_f7: got ill %b ctrl %b rw %b want 1 0000 0", illegal, alu_ctrl, reg_write); end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL decode_drain: got %b want 0", out_valid); end
    $display("test_decode done");
  endtask

  task automatic test_backpressure();
    cycle(1'b1, 32'h00100093, 32'h200, 1'b0, 1'b0);
    cycle(1'b1, 32'h00200113, 32'h204, 1'b0, 1'b0);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
    cycle(1'b1, 32'h00300193, 32'h208, 1'b0, 1'b0);  // refused
    n_checks++; if ({out_valid, in_ready, pc_out} !== {1'b1, 1'b0, 32'h200})
      begin n_fail++; $display("FAIL bp_hold: got v %b r %b pc %h want 1 0 200", out_valid, in_ready, pc_out); end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_checks++; if ({out_valid, in_ready, pc_out} !== {1'b1, 1'b1, 32'h204})
      begin n_fail++; $display("FAIL bp_second: got v %b r %b pc %h want 1 1 204", out_valid, in_ready, pc_out); end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0 (pc %h)", out_valid, pc_out); end
    $display("test_backpressure done");
  endtask

  task automatic test_flush();
    cycle(1'b1, 32'h00100093, 32'h300, 1'b0, 1'b0);
    cycle(1'b1, 32'h00200113, 32'h304, 1'b0, 1'b0);
    cycle(1'b1, 32'h00300193, 32'h308, 1'b0, 1'b1);
    n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL flush_state: got v %b r %b want 0 1", out_valid, in_ready); end
    cycle(1'b1, 32'h00400213, 32'h30C, 1'b1, 1'b0);
    n_checks++; if ({out_valid, pc_out} !== {1'b1, 32'h30C}) begin n_fail++; $display("FAIL flush_after: got v %b pc %h want 1 30c", out_valid, pc_out); end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drain: got %b want 0", out_valid); end
    $display("test_flush done");
  endtask

  task automatic test_reset_midstream();
    cycle(1'b1, 32'h00100093, 32'h400, 1'b0, 1'b0);
    cycle(1'b1, 32'h00200113, 32'h404, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    q.delete();
    n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL rst_mid_state: got v %b r %b want 0 1", out_valid, in_ready); end
    n_checks++; if ({pc_out, alu_ctrl, reg_write} !== 37'd0) begin n_fail++; $display("FAIL rst_mid_data: got %h want 0", {pc_out, alu_ctrl, reg_write}); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    $display("test_reset_midstream done");
  endtask

  task automatic test_random();
    exp_t e;
    for (int i = 0; i < 600; i++) begin
      n_checks++; if (out_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid, q.size() > 0); end
      n_checks++; if (in_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, in_ready, q.size() < 2); end
      if (q.size() > 0) begin
        e = q[0];
        n_checks++; if ({pc_out, illegal, alu_ctrl, reg_write} !== {e.pc, e.ill, e.ctrl, e.rw})
          begin n_fail++; $display("FAIL rnd_ctrl[%0d]: got pc %h ill %b ctrl %h rw %b want pc %h ill %b ctrl %h rw %b", i, pc_out, illegal, alu_ctrl, reg_write, e.pc, e.ill, e.ctrl, e.rw); end
        if (!e.ill) begin
          n_checks++; if ({alu_src_a, alu_src_b, imm_ext} !== {e.sa, e.sb, e.imm})
            begin n_fail++; $display("FAIL rnd_operands[%0d]: got sa %0d sb %b imm %h want sa %0d sb %b imm %h", i, alu_src_a, alu_src_b, imm_ext, e.sa, e.sb, e.imm); end
          n_checks++; if ({rs1, rs2, rd} !== {e.rs1, e.rs2, e.rd})
            begin n_fail++; $display("FAIL rnd_regs[%0d]: got %0d %0d %0d want %0d %0d %0d", i, rs1, rs2, rd, e.rs1, e.rs2, e.rd); end
        end
      end
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 40) == 0);
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_decode();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
